// File: rtl/seq_fetch_pkg.sv
// Shared definitions for the instruction fetch stage feeding the sequencer.
// State encodings match the values reported on the state port.
package seq_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STEP  = 2'd2,
      ST_BREAK = 2'd3
   } fetch_state_e;

   localparam int COUNT_WIDTH = 16;
   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

   function automatic logic is_writable(input fetch_state_e st);
      return (st == ST_IDLE) || (st == ST_BREAK);
   endfunction

endpackage

// File: rtl/seq_fetch_mem.sv
// Program memory: DEPTH x INST_WIDTH synchronous RAM, one read and one write port.
// The read register returns the old word when reading and writing one address.
module seq_fetch_mem #(
   parameter int INST_WIDTH = 20,
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 256
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [INST_WIDTH-1:0] rd_data,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [INST_WIDTH-1:0] wr_data
);

   logic [INST_WIDTH-1:0] mem_array [DEPTH];
   logic [INST_WIDTH-1:0] rd_data_d;
   logic [INST_WIDTH-1:0] rd_data_q;

   always_comb begin
      rd_data_d = mem_array[rd_addr];
   end

   // Only the output register is reset; program contents survive reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_array[wr_addr] <= wr_data;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/seq_fetch.sv
// Instruction fetch stage: program memory, run-control FSM with one address
// breakpoint, and an issue counter, driving inst/inst_en to the sequencer.
module seq_fetch
   import seq_fetch_pkg::*;
#(
   parameter int INST_WIDTH = 20,
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 256
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [ADDR_WIDTH-1:0]  next,
   output logic [INST_WIDTH-1:0]  inst,
   output logic                   inst_en,
   input  logic [ADDR_WIDTH-1:0]  prog_addr,
   input  logic [INST_WIDTH-1:0]  prog_data,
   input  logic                   prog_wen,
   output logic                   prog_err,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   step,
   input  logic                   bp_en,
   input  logic [ADDR_WIDTH-1:0]  bp_addr,
   output logic [1:0]             state,
   output logic [COUNT_WIDTH-1:0] issue_count
);

   fetch_state_e           state_d, state_q;
   fetch_state_e           ret_d, ret_q;
   logic                   bp_skip_d, bp_skip_q;
   logic                   inst_en_d, inst_en_q;
   logic                   prog_err_d, prog_err_q;
   logic [COUNT_WIDTH-1:0] issue_count_d, issue_count_q;
   logic                   bp_hit;
   logic                   issuing;
   logic                   mem_wen;
   logic                   clear_count;

   seq_fetch_mem #(
      .INST_WIDTH(INST_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .DEPTH     (DEPTH)
   ) u_mem (
      .clock  (clock),
      .reset  (reset),
      .rd_addr(next),
      .rd_data(inst),
      .wr_en  (mem_wen),
      .wr_addr(prog_addr),
      .wr_data(prog_data)
   );

   always_comb begin
      state_d       = state_q;
      ret_d         = ret_q;
      bp_skip_d     = 1'b0;
      clear_count   = 1'b0;
      issue_count_d = issue_count_q;

      bp_hit     = bp_en && (next == bp_addr) && !bp_skip_q;
      issuing    = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !bp_hit;
      inst_en_d  = issuing;
      mem_wen    = prog_wen && is_writable(state_q);
      prog_err_d = prog_wen && !is_writable(state_q);

      case (state_q)
         ST_IDLE: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (start) begin
               state_d     = ST_RUN;
               clear_count = 1'b1;
            end else if (step) begin
               state_d = ST_STEP;
               ret_d   = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (bp_hit) begin
               state_d = ST_BREAK;
            end
         end
         ST_STEP: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (bp_hit) begin
               state_d = ST_BREAK;
            end else begin
               state_d = ret_q;
            end
         end
         ST_BREAK: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (start) begin
               state_d = ST_RUN;
            end else if (step) begin
               state_d = ST_STEP;
               ret_d   = ST_BREAK;
            end
            // Let the breakpointed word through once on the way out.
            bp_skip_d = (state_d != ST_BREAK);
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (clear_count) begin
         issue_count_d = '0;
      end else if (issuing && (issue_count_q != COUNT_MAX)) begin
         issue_count_d = issue_count_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         ret_q         <= ST_IDLE;
         bp_skip_q     <= 1'b0;
         inst_en_q     <= 1'b0;
         prog_err_q    <= 1'b0;
         issue_count_q <= '0;
      end else begin
         state_q       <= state_d;
         ret_q         <= ret_d;
         bp_skip_q     <= bp_skip_d;
         inst_en_q     <= inst_en_d;
         prog_err_q    <= prog_err_d;
         issue_count_q <= issue_count_d;
      end
   end

   assign inst_en     = inst_en_q;
   assign prog_err    = prog_err_q;
   assign state       = state_q;
   assign issue_count = issue_count_q;

endmodule

// File: tb/tb_seq_fetch.sv
// Directed, table-driven bench for seq_fetch with hand-written sequences
// for reset mid-run, single-step and step-out-of-breakpoint.
module tb_seq_fetch;

   localparam logic [19:0] W0  = 20'hC0123;
   localparam logic [19:0] W1  = 20'hA001A;
   localparam logic [19:0] W2  = 20'h22222;
   localparam logic [19:0] W5  = 20'h55555;
   localparam logic [19:0] W1A = 20'h1A1A1;
   localparam logic [19:0] W1B = 20'h1B1B1;
   localparam logic [19:0] WFF = 20'hFFF0F;
   localparam logic [19:0] WNEW = 20'h0ABCD;

   logic        clock;
   logic        reset;
   logic [7:0]  next;
   logic [19:0] inst;
   logic        inst_en;
   logic [7:0]  prog_addr;
   logic [19:0] prog_data;
   logic        prog_wen;
   logic        prog_err;
   logic        start;
   logic        stop;
   logic        step;
   logic        bp_en;
   logic [7:0]  bp_addr;
   logic [1:0]  state;
   logic [15:0] issue_count;

   int checks;
   int errors;

   typedef struct {
      logic        start;
      logic        stop;
      logic        step;
      logic        bp_en;
      logic [7:0]  bp_addr;
      logic [7:0]  next_addr;
      logic        prog_wen;
      logic [7:0]  prog_addr;
      logic [19:0] prog_data;
      logic [19:0] exp_inst;
      logic        exp_en;
      logic [1:0]  exp_state;
      logic        exp_err;
      logic [15:0] exp_count;
   } vec_t;

   vec_t vecs[$];

   seq_fetch dut (
      .clock      (clock),
      .reset      (reset),
      .next       (next),
      .inst       (inst),
      .inst_en    (inst_en),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .prog_wen   (prog_wen),
      .prog_err   (prog_err),
      .start      (start),
      .stop       (stop),
      .step       (step),
      .bp_en      (bp_en),
      .bp_addr    (bp_addr),
      .state      (state),
      .issue_count(issue_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clearInputs();
      start     = 1'b0;
      stop      = 1'b0;
      step      = 1'b0;
      bp_en     = 1'b0;
      bp_addr   = 8'h00;
      next      = 8'h00;
      prog_wen  = 1'b0;
      prog_addr = 8'h00;
      prog_data = 20'h0;
   endtask

   task automatic addVec(input logic st, input logic sp, input logic stp,
                         input logic be, input logic [7:0] ba, input logic [7:0] na,
                         input logic pw, input logic [7:0] pa, input logic [19:0] pd,
                         input logic [19:0] ei, input logic ee, input logic [1:0] es,
                         input logic er, input logic [15:0] ec);
      vec_t v;
      v.start = st; v.stop = sp; v.step = stp; v.bp_en = be; v.bp_addr = ba;
      v.next_addr = na; v.prog_wen = pw; v.prog_addr = pa; v.prog_data = pd;
      v.exp_inst = ei; v.exp_en = ee; v.exp_state = es; v.exp_err = er; v.exp_count = ec;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      start     = v.start;
      stop      = v.stop;
      step      = v.step;
      bp_en     = v.bp_en;
      bp_addr   = v.bp_addr;
      next      = v.next_addr;
      prog_wen  = v.prog_wen;
      prog_addr = v.prog_addr;
      prog_data = v.prog_data;
   endtask

   task automatic checkOutput(input string tag, input logic [19:0] ei, input logic ee,
                              input logic [1:0] es, input logic er, input logic [15:0] ec);
      checks += 5;
      if (inst !== ei) begin
         errors++;
         $display("[TB] FAIL %s inst: got %h expected %h", tag, inst, ei);
      end
      if (inst_en !== ee) begin
         errors++;
         $display("[TB] FAIL %s inst_en: got %b expected %b", tag, inst_en, ee);
      end
      if (state !== es) begin
         errors++;
         $display("[TB] FAIL %s state: got %0d expected %0d", tag, state, es);
      end
      if (prog_err !== er) begin
         errors++;
         $display("[TB] FAIL %s prog_err: got %b expected %b", tag, prog_err, er);
      end
      if (issue_count !== ec) begin
         errors++;
         $display("[TB] FAIL %s issue_count: got %0d expected %0d", tag, issue_count, ec);
      end
   endtask

   task automatic loadWord(input logic [7:0] a, input logic [19:0] d);
      prog_wen  = 1'b1;
      prog_addr = a;
      prog_data = d;
      tick();
      prog_wen  = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clearInputs();
      reset = 1'b1;
      #2 reset = 1'b0;
      #2;
      checkOutput("reset", 20'h0, 1'b0, 2'd0, 1'b0, 16'd0);
      tick();
      reset = 1'b1;

      loadWord(8'h00, W0);
      loadWord(8'h01, W1);
      loadWord(8'h02, W2);
      loadWord(8'h05, W5);
      loadWord(8'h1A, W1A);
      loadWord(8'h1B, W1B);
      loadWord(8'hFF, WFF);

      //     st sp stp be ba     next   pw pa     pd         inst  en es    er ec
      addVec(1, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 20'h0,     W0,   0, 2'd0, 0, 16'd0);
      addVec(1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 20'h0,     W0,   0, 2'd1, 0, 16'd0);
      addVec(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 20'h0,     W0,   1, 2'd1, 0, 16'd1);
      addVec(0, 0, 0, 0, 8'h00, 8'h01, 0, 8'h00, 20'h0,     W1,   1, 2'd1, 0, 16'd2);
      addVec(0, 0, 0, 1, 8'h1A, 8'h1A, 0, 8'h00, 20'h0,     W1A,  0, 2'd3, 0, 16'd2);
      addVec(0, 0, 0, 1, 8'h1A, 8'h1A, 0, 8'h00, 20'h0,     W1A,  0, 2'd3, 0, 16'd2);
      addVec(1, 0, 0, 1, 8'h1A, 8'h1A, 0, 8'h00, 20'h0,     W1A,  0, 2'd1, 0, 16'd2);
      addVec(0, 0, 0, 1, 8'h1A, 8'h1A, 0, 8'h00, 20'h0,     W1A,  1, 2'd1, 0, 16'd3);
      addVec(0, 0, 0, 1, 8'h1A, 8'h1B, 0, 8'h00, 20'h0,     W1B,  1, 2'd1, 0, 16'd4);
      addVec(0, 0, 0, 1, 8'h1A, 8'h02, 1, 8'h05, 20'hFFFFF, W2,   1, 2'd1, 1, 16'd5);
      addVec(0, 0, 0, 1, 8'h1A, 8'h05, 0, 8'h00, 20'h0,     W5,   1, 2'd1, 0, 16'd6);
      addVec(0, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 20'h0,     W0,   1, 2'd0, 0, 16'd7);
      addVec(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 20'h0,     W0,   0, 2'd0, 0, 16'd7);
      addVec(0, 0, 0, 0, 8'h00, 8'h05, 1, 8'h05, WNEW,      W5,   0, 2'd0, 0, 16'd7);
      addVec(0, 0, 0, 0, 8'h00, 8'h05, 0, 8'h00, 20'h0,     WNEW, 0, 2'd0, 0, 16'd7);
      addVec(1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 20'h0,     W0,   0, 2'd1, 0, 16'd0);
      addVec(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 20'h0,     W0,   1, 2'd1, 0, 16'd1);
      addVec(0, 0, 0, 0, 8'h00, 8'hFF, 0, 8'h00, 20'h0,     WFF,  1, 2'd1, 0, 16'd2);
      addVec(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 20'h0,     W0,   1, 2'd1, 0, 16'd3);
      addVec(0, 1, 0, 0, 8'h00, 8'h01, 0, 8'h00, 20'h0,     W1,   1, 2'd0, 0, 16'd4);
      addVec(0, 0, 0, 0, 8'h00, 8'h01, 0, 8'h00, 20'h0,     W1,   0, 2'd0, 0, 16'd4);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         tick();
         checkOutput($sformatf("vec%0d", i), vecs[i].exp_inst, vecs[i].exp_en,
                     vecs[i].exp_state, vecs[i].exp_err, vecs[i].exp_count);
      end

      // Reset in the middle of a run clears outputs without waiting for an edge.
      clearInputs();
      start = 1'b1;
      tick();
      start = 1'b0;
      next  = 8'h01;
      tick();
      checkOutput("prerst", W1, 1'b1, 2'd1, 1'b0, 16'd1);
      #2 reset = 1'b0;
      #1;
      checkOutput("midrst", 20'h0, 1'b0, 2'd0, 1'b0, 16'd0);
      #1 reset = 1'b1;

      // Single step from IDLE, also confirming memory survived reset.
      step = 1'b1;
      next = 8'h01;
      tick();
      checkOutput("step0", W1, 1'b0, 2'd2, 1'b0, 16'd0);
      step = 1'b0;
      tick();
      checkOutput("step1", W1, 1'b1, 2'd0, 1'b0, 16'd1);
      tick();
      checkOutput("step2", W1, 1'b0, 2'd0, 1'b0, 16'd1);

      // Step out of a breakpoint issues the breakpointed word and returns to BREAK.
      bp_en   = 1'b1;
      bp_addr = 8'h1A;
      start   = 1'b1;
      next    = 8'h00;
      tick();
      checkOutput("bstart", W0, 1'b0, 2'd1, 1'b0, 16'd0);
      start = 1'b0;
      next  = 8'h1A;
      tick();
      checkOutput("bhit", W1A, 1'b0, 2'd3, 1'b0, 16'd0);
      step = 1'b1;
      tick();
      checkOutput("bstep0", W1A, 1'b0, 2'd2, 1'b0, 16'd0);
      step = 1'b0;
      tick();
      checkOutput("bstep1", W1A, 1'b1, 2'd3, 1'b0, 16'd1);
      tick();
      checkOutput("bstep2", W1A, 1'b0, 2'd3, 1'b0, 16'd1);
      stop = 1'b1;
      tick();
      checkOutput("bstop", W1A, 1'b0, 2'd0, 1'b0, 16'd1);
      clearInputs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
